// File: rtl/buffer_pkg.sv
// Constants and helpers shared by the buffers in the multiplier-to-accumulator datapath.
package buffer_pkg;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Replicated to the data width wherever an output register is cleared.
    localparam bit RESET_DATA = 1'b0;

endpackage

// File: rtl/stream_buffer_if.sv
// Producer/consumer stream bundle for stream_buffer, with occupancy status.
interface stream_buffer_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = buffer_pkg::cnt_w(DEPTH);

    // A beat transfers on a rising edge where valid & ready are both 1; valid may
    // not wait on ready, and data must be stable while valid is high and ready low.
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          almost_full;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, almost_full
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, almost_full
    );
endinterface

// File: rtl/buffer_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module buffer_ram #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [N-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [N-1:0]             rdata
);
    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_buffer.sv
// First-word-fall-through sync FIFO between the multiplier result stage and the accumulator.
module stream_buffer
    import buffer_pkg::*;
#(
    parameter int N        = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    stream_buffer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  ram_next;
    logic          push, pop;

    assign push    = bus.in_valid & bus.in_ready;
    assign pop     = bus.out_valid & bus.out_ready;
    assign rd_next = rd_ptr + AW'(1);

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // The array is written on every push; out_data mirrors mem[rd_ptr], so the
    // read port looks one entry ahead to refill the head on a pop.
    buffer_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_next),
        .rdata (ram_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            bus.out_valid   <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.almost_full <= 1'b0;
            bus.out_data    <= {N{RESET_DATA}};
        end else if (flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            bus.out_valid   <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.almost_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_next;
            cnt             <= cnt_nxt;
            bus.out_valid   <= (cnt_nxt != '0);
            bus.in_ready    <= (cnt_nxt != CW'(DEPTH));
            bus.almost_full <= (cnt_nxt >= CW'(AF_LEVEL));
            // Head only changes on a pop or when an entry lands in an empty buffer.
            if (pop) begin
                if (cnt > CW'(1)) bus.out_data <= ram_next;
                else if (push)    bus.out_data <= bus.in_data;
            end else if (cnt == '0 && push) begin
                bus.out_data <= bus.in_data;
            end
        end
    end

    assign bus.count = cnt;
endmodule

// File: tb/tb_stream_buffer.sv
// Directed bench for stream_buffer (N=32, DEPTH=4, AF_LEVEL=3).
module tb_stream_buffer;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   tests  = 0;
    int   failed = 0;
    logic [N-1:0] exp_q [$];

    stream_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    stream_buffer #(.N(N), .DEPTH(DEPTH), .AF_LEVEL(3)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [N-1:0] head;

        // Reset held two cycles with a producer trying to push.
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h99;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_almost_full", 32'(bus.almost_full), 0);

        // Pop attempt on empty must not underflow.
        bus.out_ready = 1'b1;
        tick();
        chk("empty_pop_count", 32'(bus.count), 0);
        chk("empty_pop_valid", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // Fill A0..A3 with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hA0 + 32'(i);
            tick();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_af", 32'(bus.almost_full), (i + 1 >= 3) ? 1 : 0);
            chk("fill_in_ready", 32'(bus.in_ready), (i + 1 == 4) ? 0 : 1);
            chk("fill_out_valid", 32'(bus.out_valid), 1);
            chk("fill_head", bus.out_data, 32'hA0);
        end
        bus.in_data = 32'hA4;
        tick();
        chk("full_reject_count", 32'(bus.count), 4);
        chk("full_reject_head", bus.out_data, 32'hA0);
        bus.in_valid = 1'b0;

        // Drain with backpressure pattern 1,0,1,1,1.
        begin
            logic        rdy_pat  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            logic [31:0] head_pat [5] = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
            int          cnt_pat  [5] = '{3, 3, 2, 1, 0};
            for (int i = 0; i < 5; i++) begin
                chk("drain_head", bus.out_data, head_pat[i]);
                chk("drain_valid", 32'(bus.out_valid), 1);
                bus.out_ready = rdy_pat[i];
                tick();
                chk("drain_count", 32'(bus.count), 32'(cnt_pat[i]));
            end
        end
        chk("drain_done_valid", 32'(bus.out_valid), 0);
        chk("drain_done_af", 32'(bus.almost_full), 0);

        // Streaming 1..20 with both sides always ready.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (bus.out_valid) begin
                head = exp_q.pop_front();
                chk("stream_head", bus.out_data, head);
            end
            bus.in_data = 32'(k);
            exp_q.push_back(32'(k));
            tick();
            chk("stream_count", 32'(bus.count), 1);
            chk("stream_valid", 32'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        head = exp_q.pop_front();
        chk("stream_last", bus.out_data, head);
        tick();
        chk("stream_empty_count", 32'(bus.count), 0);
        chk("stream_empty_valid", 32'(bus.out_valid), 0);
        chk("stream_q_empty", 32'(exp_q.size()), 0);

        // Full, then pop with a push attempt in the same cycle.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hB0 + 32'(i);
            tick();
        end
        chk("full2_count", 32'(bus.count), 4);
        chk("full2_in_ready", 32'(bus.in_ready), 0);
        bus.in_data   = 32'hBF;
        bus.out_ready = 1'b1;
        tick();
        chk("full_pop_count", 32'(bus.count), 3);
        chk("full_pop_in_ready", 32'(bus.in_ready), 1);
        chk("full_pop_head", bus.out_data, 32'hB1);
        bus.in_valid = 1'b0;
        tick();
        chk("pre_flush_count", 32'(bus.count), 2);
        chk("pre_flush_head", bus.out_data, 32'hB2);

        // Flush at count=2 with push and pop both asserted.
        flush = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h77;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        chk("flush_af", 32'(bus.almost_full), 0);
        bus.in_data   = 32'h55;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("post_flush_count", 32'(bus.count), 1);
        chk("post_flush_valid", 32'(bus.out_valid), 1);
        chk("post_flush_head", bus.out_data, 32'h55);
        bus.out_ready = 1'b1;
        tick();
        chk("final_count", 32'(bus.count), 0);
        chk("final_valid", 32'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
